// File: rtl/arcade_input_ctrl.sv
// arcade_input_ctrl
// Player-input front end in the clk_sys domain. This block does the following:
//   - It decodes PS/2 key events into per-player key registers.
//   - It ORs the key registers with the hps_io joystick words.
//   - It applies SOCD cleaning and coin-pulse stretching.
//   - It registers the result onto ply.
// The service keys are registered the same way onto service.
// Optional feature: define AUTOFIRE_EN to build the autofire counter/phase logic.
// Without AUTOFIRE_EN, af_mask is accepted but ignored.
//
// Handshakes:
//   - There is no valid/ready handshake.
//   - A PS/2 event is signalled by a change of ps2_key[10].
//   - The event is consumed on the first clk_sys edge that sees the change.
module arcade_input_ctrl #(
    parameter int          N_PLAYERS    = 2,
    parameter int          N_BUTTONS    = 3,
    parameter logic [15:0] COIN_CYCLES  = 16'd4800,
    parameter bit          SOCD_NEUTRAL = 1'b1,
    parameter logic [15:0] AF_HALF      = 16'd3000
) (
    input  logic                               clk_sys,
    input  logic                               RESET,
    input  logic [10:0]                        ps2_key,
    input  logic [N_PLAYERS*(7+N_BUTTONS)-1:0] joy,
    input  logic [N_BUTTONS-1:0]               af_mask,
    output logic [N_PLAYERS*(7+N_BUTTONS)-1:0] ply,
    output logic [1:0]                         service
);

    // Per-player field layout: R, L, D, U, buttons, start, coin, pause.
    localparam int W      = 7 + N_BUTTONS;
    localparam int PW     = N_PLAYERS * W;
    localparam int B_BTN  = 4;
    localparam int B_COIN = 5 + N_BUTTONS;

    // Maps a scan code to a flat bit index in the packed control vector.
    // Returns -1 in these cases:
    //   - unknown codes,
    //   - codes for a player that is not present,
    //   - codes for a button that is not present.
    // Field ids: 0..3 directions, 4..6 buttons 0..2, 7 start, 8 coin, 9 pause.
    function automatic int key_slot(input logic [7:0] code);
        int p;
        int f;
        p = -1;
        f = 0;
        case (code)
            8'h74: begin p = 0; f = 0; end
            8'h6B: begin p = 0; f = 1; end
            8'h72: begin p = 0; f = 2; end
            8'h75: begin p = 0; f = 3; end
            8'h14: begin p = 0; f = 4; end
            8'h11: begin p = 0; f = 5; end
            8'h29: begin p = 0; f = 6; end
            8'h16: begin p = 0; f = 7; end
            8'h2E: begin p = 0; f = 8; end
            8'h4D: begin p = 0; f = 9; end
            8'h34: begin p = 1; f = 0; end
            8'h23: begin p = 1; f = 1; end
            8'h2B: begin p = 1; f = 2; end
            8'h2D: begin p = 1; f = 3; end
            8'h1C: begin p = 1; f = 4; end
            8'h1B: begin p = 1; f = 5; end
            8'h15: begin p = 1; f = 6; end
            8'h1E: begin p = 1; f = 7; end
            8'h36: begin p = 1; f = 8; end
            default: p = -1;
        endcase
        if (p < 0 || p >= N_PLAYERS) return -1;
        if (f >= 4 && f <= 6) begin
            if (f - 4 >= N_BUTTONS) return -1;
            return p * W + f;
        end
        if (f >= 7) return p * W + f - 3 + N_BUTTONS;
        return p * W + f;
    endfunction

    // Keyboard state
    logic          armed_q, armed_d;
    logic          old_tog_q, old_tog_d;
    logic [PW-1:0] key_q, key_d;
    logic [1:0]    svc_q, svc_d;
    int            slot;

    // Merge / output state
    logic [PW-1:0]        raw;
    logic [PW-1:0]        ply_q, ply_d;
    logic [1:0]           service_q;
    logic [15:0]          coin_cnt_q [N_PLAYERS];
    logic [15:0]          coin_cnt_d [N_PLAYERS];
    logic [N_PLAYERS-1:0] coin_prev_q, coin_prev_d;
    logic [N_PLAYERS-1:0] coin_rise;

`ifdef AUTOFIRE_EN
    logic [15:0]                    af_cnt_q, af_cnt_d;
    logic                           af_phase_q, af_phase_d;
    logic [N_PLAYERS*N_BUTTONS-1:0] btn_raw, btn_prev_q;
    logic                           af_rise;
    logic                           unused_sink;
    assign unused_sink = ps2_key[8];
`else
    logic unused_sink;
    assign unused_sink = ^{ps2_key[8], af_mask, AF_HALF};
`endif

    // Decode one PS/2 event per toggle.
    // The first clock after reset only captures the toggle level.
    always_comb begin
        key_d     = key_q;
        svc_d     = svc_q;
        armed_d   = 1'b1;
        old_tog_d = ps2_key[10];
        slot      = key_slot(ps2_key[7:0]);
        if (armed_q && (old_tog_q != ps2_key[10])) begin
            for (int b = 0; b < PW; b++) begin
                if (slot == b) key_d[b] = ps2_key[9];
            end
            if (ps2_key[7:0] == 8'h46) svc_d[0] = ps2_key[9];
            if (ps2_key[7:0] == 8'h45) svc_d[1] = ps2_key[9];
        end
    end

    // Keyboard registers
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            armed_q   <= 1'b0;
            old_tog_q <= 1'b0;
            key_q     <= '0;
            svc_q     <= '0;
        end else begin
            armed_q   <= armed_d;
            old_tog_q <= old_tog_d;
            key_q     <= key_d;
            svc_q     <= svc_d;
        end
    end

    // Merge keyboard and joystick, then apply the remaining processing.
    // Steps, in order:
    //   1. Cancel opposing directions.
    //   2. Stretch coin.
    //   3. Apply autofire (when built).
    always_comb begin
        raw         = key_q | joy;
        ply_d       = raw;
        coin_rise   = '0;
        coin_prev_d = coin_prev_q;
        for (int p = 0; p < N_PLAYERS; p++) begin
            coin_cnt_d[p] = coin_cnt_q[p];
            if (SOCD_NEUTRAL) begin
                if (raw[p*W+2] && raw[p*W+3]) begin
                    ply_d[p*W+2] = 1'b0;
                    ply_d[p*W+3] = 1'b0;
                end
                if (raw[p*W+0] && raw[p*W+1]) begin
                    ply_d[p*W+0] = 1'b0;
                    ply_d[p*W+1] = 1'b0;
                end
            end
            // A coin edge during a running pulse is dropped; there is no retrigger.
            coin_rise[p]   = raw[p*W+B_COIN] & ~coin_prev_q[p];
            coin_prev_d[p] = raw[p*W+B_COIN];
            if (coin_rise[p] && (coin_cnt_q[p] == 16'd0)) begin
                coin_cnt_d[p] = COIN_CYCLES;
            end else if (coin_cnt_q[p] != 16'd0) begin
                coin_cnt_d[p] = coin_cnt_q[p] - 16'd1;
            end
            ply_d[p*W+B_COIN] = (coin_cnt_d[p] != 16'd0);
        end
`ifdef AUTOFIRE_EN
        for (int p = 0; p < N_PLAYERS; p++) begin
            for (int b = 0; b < N_BUTTONS; b++) begin
                btn_raw[p*N_BUTTONS+b] = raw[p*W+B_BTN+b];
            end
        end
        // A fresh press on a masked button restarts the phase high.
        // This makes the first shot fire at once.
        af_rise = |(btn_raw & ~btn_prev_q & {N_PLAYERS{af_mask}});
        if (af_rise) begin
            af_cnt_d   = 16'd0;
            af_phase_d = 1'b1;
        end else if (af_cnt_q == AF_HALF - 16'd1) begin
            af_cnt_d   = 16'd0;
            af_phase_d = ~af_phase_q;
        end else begin
            af_cnt_d   = af_cnt_q + 16'd1;
            af_phase_d = af_phase_q;
        end
        for (int p = 0; p < N_PLAYERS; p++) begin
            for (int b = 0; b < N_BUTTONS; b++) begin
                if (af_mask[b] && btn_raw[p*N_BUTTONS+b]) ply_d[p*W+B_BTN+b] = af_phase_d;
            end
        end
`endif
    end

    // Output and coin registers
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            ply_q       <= '0;
            service_q   <= '0;
            coin_prev_q <= '0;
            for (int p = 0; p < N_PLAYERS; p++) coin_cnt_q[p] <= 16'd0;
        end else begin
            ply_q       <= ply_d;
            service_q   <= svc_q;
            coin_prev_q <= coin_prev_d;
            for (int p = 0; p < N_PLAYERS; p++) coin_cnt_q[p] <= coin_cnt_d[p];
        end
    end

`ifdef AUTOFIRE_EN
    // Autofire counter, shared phase and button edge history
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            af_cnt_q   <= 16'd0;
            af_phase_q <= 1'b0;
            btn_prev_q <= '0;
        end else begin
            af_cnt_q   <= af_cnt_d;
            af_phase_q <= af_phase_d;
            btn_prev_q <= btn_raw;
        end
    end
`endif

    assign ply     = ply_q;
    assign service = service_q;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Bench for arcade_input_ctrl.
// Two instances share the same inputs:
//   - dut_a: SOCD neutral, coin pulse of 8 cycles.
//   - dut_b: SOCD pass-through, coin pulse of 5 cycles.
// A reference model predicts both instances from the key-down set and the pulse end times.
module tb_arcade_input_ctrl;

    localparam int NP     = 2;
    localparam int NB     = 3;
    localparam int W      = 7 + NB;
    localparam int PW     = NP * W;
    localparam int B_COIN = 5 + NB;

    logic          clk_sys = 1'b0;
    logic          RESET   = 1'b1;
    logic [10:0]   ps2_key = 11'h400;
    logic [PW-1:0] joy     = '0;
    logic [NB-1:0] af_mask = '0;
    logic [PW-1:0] ply_a, ply_b;
    logic [1:0]    svc_a, svc_b;

    always #5 clk_sys = ~clk_sys;

    arcade_input_ctrl #(
        .N_PLAYERS(NP), .N_BUTTONS(NB), .COIN_CYCLES(16'd8),
        .SOCD_NEUTRAL(1'b1), .AF_HALF(16'd4)
    ) dut_a (
        .clk_sys(clk_sys), .RESET(RESET), .ps2_key(ps2_key), .joy(joy),
        .af_mask(af_mask), .ply(ply_a), .service(svc_a)
    );

    arcade_input_ctrl #(
        .N_PLAYERS(NP), .N_BUTTONS(NB), .COIN_CYCLES(16'd5),
        .SOCD_NEUTRAL(1'b0), .AF_HALF(16'd4)
    ) dut_b (
        .clk_sys(clk_sys), .RESET(RESET), .ps2_key(ps2_key), .joy(joy),
        .af_mask(af_mask), .ply(ply_b), .service(svc_b)
    );

    // Scoreboard counters and checker
    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int            code_tab [NP][W];   // scan code per field, -1 = none
    bit            key_down [256];
    bit            m_armed;
    bit            m_old_tog;
    int            cyc;                // clock edges since reset release
    int            coin_end [2][NP];   // pulse is high while cyc < coin_end
    bit            coin_prev [2][NP];
    logic [PW-1:0] exp_ply [2];
    logic [1:0]    exp_svc;
    int            coin_len [2];
    int            codes [$];

    task automatic init_tables();
        code_tab[0] = '{'h74, 'h6B, 'h72, 'h75, 'h14, 'h11, 'h29, 'h16, 'h2E, 'h4D};
        code_tab[1] = '{'h34, 'h23, 'h2B, 'h2D, 'h1C, 'h1B, 'h15, 'h1E, 'h36, -1};
        coin_len[0] = 8;
        coin_len[1] = 5;
        codes = '{'h75, 'h72, 'h6B, 'h74, 'h14, 'h11, 'h29, 'h16, 'h2E, 'h4D,
                  'h2D, 'h2B, 'h23, 'h34, 'h1C, 'h1B, 'h15, 'h1E, 'h36,
                  'h46, 'h45, 'h5A, 'h01, 'h7E};
    endtask

    task automatic model_reset();
        foreach (key_down[i]) key_down[i] = 1'b0;
        m_armed   = 1'b0;
        m_old_tog = 1'b0;
        cyc       = 0;
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < NP; p++) begin
                coin_end[i][p]  = 0;
                coin_prev[i][p] = 1'b0;
            end
            exp_ply[i] = '0;
        end
        exp_svc = '0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        logic [PW-1:0] raw;
        logic [PW-1:0] e;
        bit            kb;
        bit            rise;
        cyc++;
        for (int p = 0; p < NP; p++) begin
            for (int f = 0; f < W; f++) begin
                kb = 1'b0;
                if (code_tab[p][f] >= 0) kb = key_down[code_tab[p][f]];
                raw[p*W+f] = joy[p*W+f] | kb;
            end
        end
        for (int i = 0; i < 2; i++) begin
            e = raw;
            for (int p = 0; p < NP; p++) begin
                if (i == 0) begin
                    if (raw[p*W+2] && raw[p*W+3]) begin e[p*W+2] = 1'b0; e[p*W+3] = 1'b0; end
                    if (raw[p*W+0] && raw[p*W+1]) begin e[p*W+0] = 1'b0; e[p*W+1] = 1'b0; end
                end
                rise = raw[p*W+B_COIN] && !coin_prev[i][p];
                coin_prev[i][p] = raw[p*W+B_COIN];
                if (rise && cyc > coin_end[i][p]) coin_end[i][p] = cyc + coin_len[i];
                e[p*W+B_COIN] = (cyc < coin_end[i][p]);
            end
            exp_ply[i] = e;
        end
        exp_svc = {key_down['h45], key_down['h46]};
        if (m_armed && (m_old_tog != ps2_key[10])) key_down[ps2_key[7:0]] = ps2_key[9];
        m_old_tog = ps2_key[10];
        m_armed   = 1'b1;
    endtask

    // Driver tasks
    task automatic send_key(input bit pressed, input logic [7:0] code);
        ps2_key = {~ps2_key[10], pressed, 1'($urandom_range(0, 1)), code};
    endtask

    task automatic step();
        @(posedge clk_sys);
        model_edge();
        #1;
        check_eq("ply_a", 32'(ply_a), 32'(exp_ply[0]));
        check_eq("ply_b", 32'(ply_b), 32'(exp_ply[1]));
        check_eq("svc_a", 32'(svc_a), 32'(exp_svc));
        check_eq("svc_b", 32'(svc_b), 32'(exp_svc));
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_ply_a"}, 32'(ply_a), 32'd0);
        check_eq({tag, "_ply_b"}, 32'(ply_b), 32'd0);
        check_eq({tag, "_svc_a"}, 32'(svc_a), 32'd0);
        check_eq({tag, "_svc_b"}, 32'(svc_b), 32'd0);
    endtask

    task automatic rst_step();
        @(posedge clk_sys);
        #1;
        check_zero("rst");
    endtask

    initial begin
        init_tables();
        model_reset();
        // Reset with the toggle bit held high; no event may appear after release.
        repeat (10) rst_step();
        RESET = 1'b0;
        repeat (10) step();

        // Keyboard press and release of P0 up
        send_key(1'b1, 8'h75); repeat (4) step();
        send_key(1'b0, 8'h75); repeat (4) step();

        // Opposing directions from joystick and keyboard
        joy[3] = 1'b1; send_key(1'b1, 8'h72); repeat (4) step();
        send_key(1'b0, 8'h72); repeat (2) step();
        joy[3] = 1'b0; joy[W+0] = 1'b1; send_key(1'b1, 8'h23); repeat (4) step();
        send_key(1'b0, 8'h23); joy[W+0] = 1'b0; repeat (3) step();

        // P1 coin: 3 clk high, second edge 4 clk later is swallowed
        joy[W+B_COIN] = 1'b1; repeat (3) step();
        joy[W+B_COIN] = 1'b0; repeat (4) step();
        joy[W+B_COIN] = 1'b1; repeat (2) step();
        joy[W+B_COIN] = 1'b0; repeat (12) step();

        // Long coin hold still yields one pulse
        joy[B_COIN] = 1'b1; repeat (20) step();
        joy[B_COIN] = 1'b0; repeat (3) step();

        // Autofire mask with B0 held: steady pass-through in this build
        af_mask = 3'b001; joy[4] = 1'b1; repeat (20) step();
        joy[4] = 1'b0; af_mask = 3'b000; repeat (2) step();

        // Service keys
        send_key(1'b1, 8'h46); repeat (3) step();
        send_key(1'b1, 8'h45); repeat (3) step();
        send_key(1'b0, 8'h46); repeat (3) step();
        send_key(1'b0, 8'h45); repeat (3) step();

        // Reset mid coin pulse and mid key hold; only live joystick bits return
        send_key(1'b1, 8'h2E); repeat (2) step();
        send_key(1'b1, 8'h75); joy[W+0] = 1'b1; repeat (3) step();
        RESET = 1'b1;
        #1;
        check_zero("async");
        model_reset();
        repeat (2) rst_step();
        RESET = 1'b0;
        repeat (4) step();
        joy[W+0] = 1'b0;
        step();

        // Randomised traffic
        repeat (1500) begin
            if ($urandom_range(0, 3) == 0)
                send_key(1'($urandom_range(0, 1)), 8'(codes[$urandom_range(0, codes.size() - 1)]));
            for (int b = 0; b < PW; b++) begin
                if ($urandom_range(0, 9) == 0) joy[b] = ~joy[b];
            end
            if ($urandom_range(0, 31) == 0) af_mask = 3'($urandom_range(0, 7));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
